// File: rtl/psum_drain_ctrl_if.sv
// Bundle of the drain controller's control, OFIFO-read and psum-SRAM-write signals.
// The master side kicks transfers and supplies OFIFO data; the slave side is the drain controller.
interface psum_drain_ctrl_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_w  = 11
) ();
   logic                     start;
   logic [addr_w-1:0]        base_addr;
   logic [addr_w-1:0]        num_vec;
   logic                     relu_en;
   logic                     ofifo_valid;
   logic [psum_bw*col-1:0]   ofifo_out;
   logic                     ofifo_rd;
   logic                     mem_cen;
   logic                     mem_wen;
   logic [addr_w-1:0]        mem_a;
   logic [psum_bw*col-1:0]   mem_d;
   logic                     busy;
   logic                     done;

   modport master (
      output start, base_addr, num_vec, relu_en, ofifo_valid, ofifo_out,
      input  ofifo_rd, mem_cen, mem_wen, mem_a, mem_d, busy, done
   );

   modport slave (
      input  start, base_addr, num_vec, relu_en, ofifo_valid, ofifo_out,
      output ofifo_rd, mem_cen, mem_wen, mem_a, mem_d, busy, done
   );
endinterface

// File: rtl/psum_drain_ctrl.sv
// Psum drain stage: pops psum vectors from the corelet OFIFO and writes them, one per cycle,
// to consecutive psum SRAM addresses, with optional per-lane signed ReLU on the way.
// A pop at edge N presents the SRAM write in cycle N+1; done pulses the cycle after the last write.
module psum_drain_ctrl #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_w  = 11
) (
   input  logic               clk,
   input  logic               reset,
   psum_drain_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   localparam int VW = psum_bw * col;

   state_e              state_q, state_d;
   logic [addr_w-1:0]   rem_q;     // vectors still to pop
   logic [addr_w-1:0]   wptr_q;    // address for the next captured vector
   logic                relu_q;    // ReLU enable latched for this transfer
   logic                wpend_q;   // a captured vector is being written this cycle
   logic [VW-1:0]       wreg_q;    // write-data register, drives mem_d
   logic [addr_w-1:0]   mem_a_q;   // write-address register, drives mem_a
   logic [VW-1:0]       relu_vec;
   logic                rd;

   // Pop only in RUN, only when the OFIFO has a vector and this transfer still needs one.
   assign rd = (state_q == RUN) && bus.ofifo_valid && (rem_q != '0);

   // Per-lane ReLU on the OFIFO head: a set sign bit clamps the lane to zero.
   always_comb begin
      relu_vec = bus.ofifo_out;
      for (int l = 0; l < col; l++) begin
         if (relu_q && bus.ofifo_out[l*psum_bw + psum_bw - 1]) begin
            relu_vec[l*psum_bw +: psum_bw] = '0;
         end
      end
   end

   // Next-state logic. rem reaches zero only on a pop edge, so rem==0 in RUN means either the
   // final write is on the bus now or the transfer was empty; both leave for FIN next cycle.
   always_comb begin
      // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start)      state_d = RUN;
         RUN:  if (rem_q == '0)    state_d = FIN;
         FIN:                      state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // State register; an async reset abandons any transfer without a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: all sequential state uses non-blocking assignment so every flop sees pre-edge values.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Transfer parameters, pop capture and write stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q   <= '0;
         wptr_q  <= '0;
         relu_q  <= 1'b0;
         wpend_q <= 1'b0;
         // NOTE: wreg_q is a flop bank rather than a RAM, so it takes the async clear like the rest.
         wreg_q  <= '0;
         mem_a_q <= '0;
      end else begin
         if (state_q == IDLE && bus.start) begin
            rem_q  <= bus.num_vec;
            wptr_q <= bus.base_addr;
            relu_q <= bus.relu_en;
         end
         wpend_q <= rd;
         if (rd) begin
            wreg_q  <= relu_vec;
            rem_q   <= rem_q - addr_w'(1);
            mem_a_q <= wptr_q;
            wptr_q  <= wptr_q + addr_w'(1);   // wraps modulo 2^addr_w
         end
      end
   end

   assign bus.ofifo_rd = rd;
   assign bus.mem_cen  = ~wpend_q;
   assign bus.mem_wen  = ~wpend_q;
   assign bus.mem_a    = mem_a_q;
   assign bus.mem_d    = wreg_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == FIN);

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed bench for psum_drain_ctrl. A model OFIFO feeds the DUT; each vector pushed also
// pushes its expected SRAM write (address, ReLU'd data) to a scoreboard that a negedge monitor
// pops whenever the DUT presents a write. Per-cycle rd/write/busy/done patterns are compared too.
module tb_psum_drain_ctrl;

   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int AW  = 11;
   localparam int VW  = COL * BW;

   typedef struct {
      logic [AW-1:0] a;
      logic [VW-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [VW-1:0] fifo[$];
   wr_t           exp_q[$];

   logic [15:0] rdv, wrv, busyv, donev;
   logic [VW-1:0] v2;

   psum_drain_ctrl_if #(.col(COL), .psum_bw(BW), .addr_w(AW)) bus ();

   psum_drain_ctrl #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] relu_model(input logic [VW-1:0] v, input bit en);
      logic [VW-1:0] r;
      logic [BW-1:0] lane;
      r = v;
      for (int l = 0; l < COL; l++) begin
         lane = v[l*BW +: BW];
         if (en && $signed(lane) < 0) r[l*BW +: BW] = '0;
      end
      return r;
   endfunction

   task automatic push_vec(input logic [VW-1:0] v, input logic [AW-1:0] a, input bit relu);
      wr_t w;
      fifo.push_back(v);
      w.a = a;
      w.d = relu_model(v, relu);
      exp_q.push_back(w);
   endtask

   task automatic setup(input logic [AW-1:0] base, input logic [AW-1:0] n, input bit relu);
      bus.base_addr = base;
      bus.num_vec   = n;
      bus.relu_en   = relu;
   endtask

   // Runs n cycles from just after a rising edge. Cycle i drives start=spat[i] and offers the
   // model OFIFO head when vpat[i] is set; the DUT response is sampled mid-cycle.
   task automatic run(input int n, input logic [15:0] spat, input logic [15:0] vpat,
                      output logic [15:0] rd_o, output logic [15:0] wr_o,
                      output logic [15:0] busy_o, output logic [15:0] done_o);
      rd_o = '0; wr_o = '0; busy_o = '0; done_o = '0;
      for (int i = 0; i < n; i++) begin
         bus.start       = spat[i];
         bus.ofifo_valid = vpat[i] && (fifo.size() != 0);
         bus.ofifo_out   = (fifo.size() != 0) ? fifo[0] : '0;
         @(negedge clk);
         rd_o[i]   = bus.ofifo_rd;
         wr_o[i]   = ~bus.mem_cen;
         busy_o[i] = bus.busy;
         done_o[i] = bus.done;
         check("rd_without_valid", {127'd0, bus.ofifo_rd & ~bus.ofifo_valid}, '0);
         @(posedge clk);
         #1;
         if (rd_o[i]) void'(fifo.pop_front());
      end
      bus.start       = 1'b0;
      bus.ofifo_valid = 1'b0;
   endtask

   // Scoreboard monitor: every presented SRAM write must match the oldest expected write.
   always @(negedge clk) begin
      wr_t w;
      if (bus.mem_cen === 1'b0) begin
         check("wr_wen", {127'd0, bus.mem_wen}, '0);
         check("wr_expected", {127'd0, exp_q.size() != 0}, {127'd0, 1'b1});
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("wr_addr", {117'd0, bus.mem_a}, {117'd0, w.a});
            check("wr_data", bus.mem_d, w.d);
         end
      end
   end

   initial begin
      bus.start = 1'b0; bus.base_addr = '0; bus.num_vec = '0; bus.relu_en = 1'b0;
      bus.ofifo_valid = 1'b0; bus.ofifo_out = '0;

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst_cen",  {127'd0, bus.mem_cen}, {127'd0, 1'b1});
      check("rst_wen",  {127'd0, bus.mem_wen}, {127'd0, 1'b1});
      check("rst_busy", {127'd0, bus.busy}, '0);
      check("rst_done", {127'd0, bus.done}, '0);
      check("rst_rd",   {127'd0, bus.ofifo_rd}, '0);
      check("rst_a",    {117'd0, bus.mem_a}, '0);
      check("rst_d",    bus.mem_d, '0);
      @(posedge clk); #1 rst = 1'b0;

      // 1: four vectors of +5 at 0x010, valid held high
      setup(11'h010, 11'd4, 1'b0);
      for (int i = 0; i < 4; i++) push_vec({COL{16'h0005}}, 11'h010 + 11'(i), 1'b0);
      run(8, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t1_rd",   {112'd0, rdv},   {112'd0, 16'h001E});
      check("t1_wr",   {112'd0, wrv},   {112'd0, 16'h003C});
      check("t1_busy", {112'd0, busyv}, {112'd0, 16'h003E});
      check("t1_done", {112'd0, donev}, {112'd0, 16'h0040});
      check("t1_sb_drained", 128'(exp_q.size()), '0);

      // 2: ReLU on and off with negative, positive and extreme lanes
      v2 = {8{16'h1234}};
      v2[0*BW +: BW] = 16'hFFFD;
      v2[1*BW +: BW] = 16'h0007;
      v2[2*BW +: BW] = 16'h8000;
      v2[3*BW +: BW] = 16'h7FFF;
      v2[4*BW +: BW] = 16'hFFFF;
      setup(11'h100, 11'd1, 1'b1);
      push_vec(v2, 11'h100, 1'b1);
      run(5, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t2_relu_wr",   {112'd0, wrv},   {112'd0, 16'h0004});
      check("t2_relu_done", {112'd0, donev}, {112'd0, 16'h0008});
      check("t2_relu_lanes", bus.mem_d, {{3{16'h1234}}, 16'h0000, 16'h7FFF, 16'h0000, 16'h0007, 16'h0000});
      setup(11'h101, 11'd1, 1'b0);
      push_vec(v2, 11'h101, 1'b0);
      run(5, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t2_pass_lanes", bus.mem_d, v2);
      check("t2_sb_drained", 128'(exp_q.size()), '0);

      // 3: stalls 1,0,0,1,1 with num_vec=3; a fourth vector waits but must not be popped
      setup(11'h200, 11'd3, 1'b0);
      for (int i = 0; i < 3; i++) push_vec({COL{16'(16'h0A00 + i)}}, 11'h200 + 11'(i), 1'b0);
      fifo.push_back({COL{16'hDEAD}});
      run(9, 16'h0001, 16'h01F2, rdv, wrv, busyv, donev);
      check("t3_rd",   {112'd0, rdv},   {112'd0, 16'h0032});
      check("t3_wr",   {112'd0, wrv},   {112'd0, 16'h0064});
      check("t3_busy", {112'd0, busyv}, {112'd0, 16'h007E});
      check("t3_done", {112'd0, donev}, {112'd0, 16'h0080});
      check("t3_left_in_fifo", 128'(fifo.size()), 128'd1);
      check("t3_sb_drained", 128'(exp_q.size()), '0);
      fifo.delete();

      // 4a: address wrap 0x7FE, 0x7FF, 0x000
      setup(11'h7FE, 11'd3, 1'b0);
      for (int i = 0; i < 3; i++) push_vec({COL{16'(16'hC000 + i)}}, 11'h7FE + 11'(i), 1'b0);
      run(7, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t4_wrap_wr",   {112'd0, wrv},   {112'd0, 16'h001C});
      check("t4_wrap_done", {112'd0, donev}, {112'd0, 16'h0020});
      check("t4_sb_drained", 128'(exp_q.size()), '0);

      // 4b: num_vec=0 -> done two cycles after start, no SRAM access
      setup(11'h055, 11'd0, 1'b0);
      run(5, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t4_zero_rd",   {112'd0, rdv},   '0);
      check("t4_zero_wr",   {112'd0, wrv},   '0);
      check("t4_zero_busy", {112'd0, busyv}, {112'd0, 16'h0002});
      check("t4_zero_done", {112'd0, donev}, {112'd0, 16'h0004});

      // 5: reset after 2 of 5 pops, then a fresh transfer from a new base
      setup(11'h300, 11'd5, 1'b0);
      for (int i = 0; i < 5; i++) push_vec({COL{16'(16'h3000 + i)}}, 11'h300 + 11'(i), 1'b0);
      run(3, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t5_rd_before_rst", {112'd0, rdv}, {112'd0, 16'h0006});
      bus.ofifo_valid = 1'b1;
      rst = 1'b1;
      #1;
      check("t5_rst_cen",  {127'd0, bus.mem_cen}, {127'd0, 1'b1});
      check("t5_rst_wen",  {127'd0, bus.mem_wen}, {127'd0, 1'b1});
      check("t5_rst_busy", {127'd0, bus.busy}, '0);
      check("t5_rst_done", {127'd0, bus.done}, '0);
      check("t5_rst_rd",   {127'd0, bus.ofifo_rd}, '0);
      check("t5_rst_a",    {117'd0, bus.mem_a}, '0);
      check("t5_rst_d",    bus.mem_d, '0);
      bus.ofifo_valid = 1'b0;
      exp_q.delete();
      fifo.delete();
      @(posedge clk); #1 rst = 1'b0;
      run(3, 16'h0000, 16'h0000, rdv, wrv, busyv, donev);
      check("t5_no_done", {112'd0, donev}, '0);
      check("t5_no_busy", {112'd0, busyv}, '0);
      setup(11'h400, 11'd2, 1'b0);
      for (int i = 0; i < 2; i++) push_vec({COL{16'(16'h4400 + i)}}, 11'h400 + 11'(i), 1'b0);
      run(6, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t5_new_wr",   {112'd0, wrv},   {112'd0, 16'h000C});
      check("t5_new_done", {112'd0, donev}, {112'd0, 16'h0010});
      check("t5_sb_drained", 128'(exp_q.size()), '0);

      // 6: start pulses mid-transfer and during FIN with a different base are ignored
      setup(11'h500, 11'd3, 1'b0);
      for (int i = 0; i < 3; i++) push_vec({COL{16'(16'h5500 + i)}}, 11'h500 + 11'(i), 1'b0);
      run(1, 16'h0001, 16'hFFFF, rdv, wrv, busyv, donev);
      setup(11'h600, 11'd7, 1'b1);
      run(8, 16'h0012, 16'hFFFF, rdv, wrv, busyv, donev);
      check("t6_rd",   {112'd0, rdv},   {112'd0, 16'h0007});
      check("t6_wr",   {112'd0, wrv},   {112'd0, 16'h000E});
      check("t6_busy", {112'd0, busyv}, {112'd0, 16'h000F});
      check("t6_done", {112'd0, donev}, {112'd0, 16'h0010});
      check("t6_sb_drained", 128'(exp_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
